// File: rtl/rate_divider.sv
// Programmable tick generator: one-cycle Enable every 1, F, 2F or 4F cycles.
// Optional RATE_DIVIDER_SINGLE_STEP_EN adds a Step input for manual ticks in HOLD.
module rate_divider #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int WIDTH           = 28
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [1:0]       Speed,
`ifdef RATE_DIVIDER_SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic             Enable,
  output logic [WIDTH-1:0] RateCount
);

  localparam longint F = longint'(CLOCK_FREQUENCY);

  localparam logic [WIDTH-1:0] R1 = WIDTH'(F - 1);
  localparam logic [WIDTH-1:0] R2 = WIDTH'(2 * F - 1);
  localparam logic [WIDTH-1:0] R4 = WIDTH'(4 * F - 1);

  typedef enum logic [1:0] {
    LOAD,
    COUNT,
    HOLD
  } state_t;

  state_t           state;
  logic [1:0]       speed_q;
  logic [WIDTH-1:0] reload;
  logic             speed_chg;
  logic             at_zero;
  logic             step_rise;

  always_comb begin
    reload = '0;
    unique case (Speed)
      2'b00: reload = '0;
      2'b01: reload = R1;
      2'b10: reload = R2;
      2'b11: reload = R4;
    endcase
  end

  assign speed_chg = (Speed != speed_q);
  assign at_zero   = (RateCount == '0);

`ifdef RATE_DIVIDER_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= Step;
    end
  end

  assign step_rise = Step & ~step_q;
`else
  assign step_rise = 1'b0;
`endif

  // Speed change outranks Run and the zero-count pulse in every state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= LOAD;
      RateCount <= '0;
      Enable    <= 1'b0;
      speed_q   <= 2'b00;
    end else begin
      speed_q <= Speed;
      Enable  <= 1'b0;
      case (state)
        LOAD: begin
          RateCount <= reload;
          state     <= Run ? COUNT : HOLD;
        end
        COUNT: begin
          if (speed_chg) begin
            state <= LOAD;
          end else if (!Run) begin
            state <= HOLD;
          end else if (at_zero) begin
            RateCount <= reload;
            Enable    <= 1'b1;
          end else begin
            RateCount <= RateCount - WIDTH'(1);
          end
        end
        HOLD: begin
          if (speed_chg) begin
            state <= LOAD;
          end else if (Run) begin
            state <= COUNT;
          end else if (step_rise) begin
            Enable <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
